// File: rtl/sat_simd_au_pipe.sv
// rtl/sat_simd_au_pipe.sv - two-stage saturating ADD/SUB/PADD/PSUB execute unit with Z/V/N/C flags
// Optional sticky overflow register enabled by macro SAT_AU_STICKY_V_EN.
module sat_simd_au_pipe #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_cmd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_z,
    output logic             out_v,
    output logic             out_n,
    output logic             out_c,
    input  logic             v_clr,
    output logic             sticky_v
);

    localparam int LW = WIDTH / LANES;

    logic             s1_valid;
    logic [1:0]       s1_cmd;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic s2_load;
    logic s1_advance;

    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cmd   <= 2'b00;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cmd <= in_cmd;
                s1_a   <= in_a;
                s1_b   <= in_b;
            end
        end
    end

    // cmd[0] selects subtract, cmd[1] selects the packed-lane datapath
    logic             s1_sub;
    logic             s1_packed;
    logic [WIDTH-1:0] b_eff;

    assign s1_sub    = s1_cmd[0];
    assign s1_packed = s1_cmd[1];
    assign b_eff     = s1_b ^ {WIDTH{s1_sub}};

    // Full-width path
    logic [WIDTH:0]   full_sum;
    logic             full_v;
    logic [WIDTH-1:0] full_res;

    assign full_sum = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, s1_sub};
    assign full_v   = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (full_sum[WIDTH-1] != s1_a[WIDTH-1]);
    assign full_res = full_v ? {s1_a[WIDTH-1], {(WIDTH-1){~s1_a[WIDTH-1]}}}
                             : full_sum[WIDTH-1:0];

    // Packed path: each lane has its own carry-in and never sees a neighbour's carry
    logic [WIDTH-1:0] lane_res;
    logic [LANES-1:0] lane_v;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LW-1:0] la;
        logic [LW-1:0] lb;
        logic [LW:0]   ls;
        logic          lv;

        assign la = s1_a[i*LW +: LW];
        assign lb = b_eff[i*LW +: LW];
        assign ls = {1'b0, la} + {1'b0, lb} + {{LW{1'b0}}, s1_sub};
        assign lv = (la[LW-1] == lb[LW-1]) && (ls[LW-1] != la[LW-1]);

        assign lane_res[i*LW +: LW] = lv ? {la[LW-1], {(LW-1){~la[LW-1]}}} : ls[LW-1:0];
        assign lane_v[i]            = lv;
    end

    logic [WIDTH-1:0] sel_res;
    logic             sel_v;
    logic             sel_c;

    assign sel_res = s1_packed ? lane_res : full_res;
    assign sel_v   = s1_packed ? (|lane_v) : full_v;
    assign sel_c   = s1_packed ? 1'b0 : full_sum[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_z      <= 1'b0;
            out_v      <= 1'b0;
            out_n      <= 1'b0;
            out_c      <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= sel_res;
                out_z      <= (sel_res == '0);
                out_v      <= sel_v;
                out_n      <= sel_res[WIDTH-1];
                out_c      <= sel_c;
            end
        end
    end

`ifdef SAT_AU_STICKY_V_EN
    logic sticky_q;

    // A setting transfer takes priority over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (out_valid && out_ready && out_v) begin
            sticky_q <= 1'b1;
        end else if (v_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign sticky_v = sticky_q;
`else
    logic unused_v_clr;

    assign unused_v_clr = v_clr;
    assign sticky_v     = 1'b0;
`endif

endmodule

// File: tb/tb_sat_simd_au_pipe.sv
// tb/tb_sat_simd_au_pipe.sv - scoreboard bench for sat_simd_au_pipe at WIDTH=16, LANES=2
module tb_sat_simd_au_pipe;

    localparam int W  = 16;
    localparam int L  = 2;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         v;
        logic         n;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_cmd;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_z;
    logic         out_v;
    logic         out_n;
    logic         out_c;
    logic         v_clr;
    logic         sticky_v;

    int   vectors = 0;
    int   errs    = 0;
    int   cyc     = 0;
    exp_t sbq[$];
    int   out_cyc[$];
    exp_t mon_e;
    bit   rand_bp = 1'b0;

    sat_simd_au_pipe #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_z(out_z), .out_v(out_v), .out_n(out_n), .out_c(out_c),
        .v_clr(v_clr), .sticky_v(sticky_v)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic z, v, n, c);
        exp_t e;
        e.res = r; e.z = z; e.v = v; e.n = n; e.c = c;
        return e;
    endfunction

    // Reference: signed integer arithmetic with clamping per lane
    function automatic exp_t model(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int nl, lw, ua, ub, sa, sb, r, mx, mn, acc;
        logic v;
        nl  = cmd[1] ? L : 1;
        lw  = W / nl;
        acc = 0;
        v   = 1'b0;
        for (int i = 0; i < nl; i++) begin
            ua = int'(a >> (i*lw)) & ((1 << lw) - 1);
            ub = int'(b >> (i*lw)) & ((1 << lw) - 1);
            sa = (ua >= (1 << (lw-1))) ? ua - (1 << lw) : ua;
            sb = (ub >= (1 << (lw-1))) ? ub - (1 << lw) : ub;
            r  = cmd[0] ? sa - sb : sa + sb;
            mx = (1 << (lw-1)) - 1;
            mn = -(1 << (lw-1));
            if (r > mx) begin r = mx; v = 1'b1; end
            else if (r < mn) begin r = mn; v = 1'b1; end
            acc = acc | ((r & ((1 << lw) - 1)) << (i*lw));
        end
        e.res = acc[15:0];
        e.z   = (acc[15:0] == 16'h0000);
        e.n   = acc[15];
        e.v   = v;
        if (cmd[1])      e.c = 1'b0;
        else if (cmd[0]) e.c = (a >= b);
        else             e.c = ((int'(a) + int'(b)) > 65535);
        return e;
    endfunction

    task automatic drive(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b, input exp_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_a     = a;
        in_b     = b;
        for (int t = 0; t < 200 && !done; t++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                sbq.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sbq.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", {16'h0, out_result}, 32'hFFFFFFFF);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", {16'h0, out_result}, {16'h0, mon_e.res});
                chk("flags_zvnc", {28'h0, out_z, out_v, out_n, out_c},
                    {28'h0, mon_e.z, mon_e.v, mon_e.n, mon_e.c});
                out_cyc.push_back(cyc);
            end
        end
    end

    logic [15:0] bp_a[4] = '{16'h0010, 16'h1000, 16'h7070, 16'h8080};
    logic [15:0] bp_b[4] = '{16'h0020, 16'h0001, 16'h2020, 16'h0101};
    logic [1:0]  bp_c[4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        int idx;
        logic [1:0]  rc;
        logic [15:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; in_cmd = 2'b00; in_a = '0; in_b = '0;
        out_ready = 1'b1; v_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", {out_z, out_v, out_n, out_c}, 0);
        chk("rst_sticky", sticky_v, 0);
        @(posedge clk); #1;

        // Beat presented after edge k, captured by S1 at k+1, result visible after k+2
        drive(2'b00, 16'h7FFF, 16'h0001, mk(16'h7FFF, 0, 1, 0, 0));
        chk("lat_s1_only", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_out_valid", out_valid, 1);
        chk("lat_out_result", out_result, 16'h7FFF);
        @(posedge clk); #1;
`ifdef SAT_AU_STICKY_V_EN
        chk("sticky_set", sticky_v, 1);
        v_clr = 1'b1;
        @(posedge clk); #1;
        v_clr = 1'b0;
        chk("sticky_clr", sticky_v, 0);
`else
        chk("sticky_tied0", sticky_v, 0);
`endif

        drive(2'b01, 16'h8000, 16'h0001, mk(16'h8000, 0, 1, 1, 1));
        drive(2'b01, 16'h0003, 16'h0005, mk(16'hFFFE, 0, 0, 1, 0));
        drive(2'b10, 16'h7F80, 16'h0180, mk(16'h7F80, 0, 1, 0, 0));
        drive(2'b10, 16'h00FF, 16'h0001, mk(16'h0000, 1, 0, 0, 0));
        drive(2'b11, 16'h0505, 16'h0505, mk(16'h0000, 1, 0, 0, 0));
        drain();

        out_cyc.delete();
        drive(2'b00, 16'd1, 16'd1, mk(16'd2, 0, 0, 0, 0));
        drive(2'b00, 16'd2, 16'd2, mk(16'd4, 0, 0, 0, 0));
        drive(2'b00, 16'd3, 16'd3, mk(16'd6, 0, 0, 0, 0));
        drain();
        chk("b2b_count", out_cyc.size(), 3);
        if (out_cyc.size() == 3) begin
            chk("b2b_gap01", out_cyc[1] - out_cyc[0], 1);
            chk("b2b_gap12", out_cyc[2] - out_cyc[1], 1);
        end

        // Backpressure: two beats fit (S1 + S2), then the input stalls
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        in_cmd = bp_c[0]; in_a = bp_a[0]; in_b = bp_b[0];
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (in_ready && idx < 4) begin
                sbq.push_back(model(bp_c[idx], bp_a[idx], bp_b[idx]));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 4) begin
                in_cmd = bp_c[idx]; in_a = bp_a[idx]; in_b = bp_b[idx];
            end
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        mon_e = model(bp_c[0], bp_a[0], bp_b[0]);
        chk("bp_held_result", out_result, mon_e.res);
        @(posedge clk); #1;
        chk("bp_held_result2", out_result, mon_e.res);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 2; i < 4; i++) drive(bp_c[i], bp_a[i], bp_b[i], model(bp_c[i], bp_a[i], bp_b[i]));
        drain();

        // Reset with two beats in flight
        drive(2'b00, 16'h1111, 16'h1111, model(2'b00, 16'h1111, 16'h1111));
        drive(2'b00, 16'h2222, 16'h2222, model(2'b00, 16'h2222, 16'h2222));
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            chk("post_rst_no_out", out_valid, 0);
        end

`ifdef SAT_AU_STICKY_V_EN
        out_ready = 1'b0;
        drive(2'b00, 16'h7FFF, 16'h0001, mk(16'h7FFF, 0, 1, 0, 0));
        repeat (2) begin @(posedge clk); #1; end
        chk("collide_pre", sticky_v, 0);
        v_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        v_clr = 1'b0;
        chk("collide_set_wins", sticky_v, 1);
        drain();
`endif

        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rc = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            drive(rc, ra, rb, model(rc, ra, rb));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
